// File: rtl/dma_ctrl_regs_pkg.sv
// Shared definitions for the DMA control/status register file: address map,
// status bit positions and small combinational helpers.
package dma_ctrl_regs_pkg;

  localparam int ADDR_W = 11;

  localparam logic [ADDR_W-1:0] ADDR_VER        = 11'h000;
  localparam logic [ADDR_W-1:0] ADDR_START      = 11'h004;
  localparam logic [ADDR_W-1:0] ADDR_BUSY       = 11'h008;
  localparam logic [ADDR_W-1:0] ADDR_INT_STATUS = 11'h00C;
  localparam logic [ADDR_W-1:0] ADDR_INT_MASK   = 11'h010;
  localparam logic [ADDR_W-1:0] ADDR_DONE_CNT   = 11'h014;

  localparam int STERR_BIT = 31;
  localparam int POPCNT_W  = 6;

  // One-hot register select; all-zero means an unmapped address.
  typedef struct packed {
    logic ver;
    logic start;
    logic busy;
    logic status;
    logic mask;
    logic cnt;
  } reg_sel_t;

  function automatic reg_sel_t decode_addr(input logic [ADDR_W-1:0] addr);
    reg_sel_t sel;
    sel        = '0;
    sel.ver    = (addr == ADDR_VER);
    sel.start  = (addr == ADDR_START);
    sel.busy   = (addr == ADDR_BUSY);
    sel.status = (addr == ADDR_INT_STATUS);
    sel.mask   = (addr == ADDR_INT_MASK);
    sel.cnt    = (addr == ADDR_DONE_CNT);
    return sel;
  endfunction

  function automatic logic [31:0] strb_to_mask(input logic [3:0] strb);
    logic [31:0] mask;
    mask = '0;
    for (int i = 0; i < 4; i++) begin
      mask[8*i +: 8] = {8{strb[i]}};
    end
    return mask;
  endfunction

  function automatic logic [POPCNT_W-1:0] popcount(input logic [31:0] vec);
    logic [POPCNT_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < 32; i++) begin
      cnt = cnt + {{(POPCNT_W-1){1'b0}}, vec[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/dma_ctrl_regs_v2_sat_counter.sv
// Width-parametrised saturating accumulator; a clear restarts the sum from
// zero while still adding the same-cycle increment.
module dma_ctrl_sat_counter #(
  parameter int W     = 16,
  parameter int INC_W = 6
) (
  input  logic             clk_i,
  input  logic             srst_i,
  input  logic             clr_i,
  input  logic [INC_W-1:0] inc_i,
  output logic [W-1:0]     cnt_o
);

  localparam int SW = W + INC_W;
  localparam logic [SW-1:0] MAX_VAL = {{INC_W{1'b0}}, {W{1'b1}}};

  logic [W-1:0]  cnt_q;
  logic [W-1:0]  cnt_d;
  logic [SW-1:0] base;
  logic [SW-1:0] sum;

  always_comb begin
    base  = clr_i ? '0 : {{INC_W{1'b0}}, cnt_q};
    sum   = base + {{W{1'b0}}, inc_i};
    cnt_d = (sum > MAX_VAL) ? {W{1'b1}} : sum[W-1:0];
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/dma_ctrl_regs_v2.sv
// Control/status register file for the DMA engine: version, per-BD start and
// busy tracking, sticky W1C interrupt status with mask, completion counter.
module dma_ctrl_regs_v2
  import dma_ctrl_regs_pkg::*;
#(
  parameter int MAJOR_VER_NUM = 0,
  parameter int MINOR_VER_NUM = 0,
  parameter int BUILD_NUM     = 0,
  parameter int NUM_INT_BDS   = 4,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   ctrlSel,
  input  logic                   ctrlWr,
  input  logic [10:0]            ctrlAddr,
  input  logic [31:0]            ctrlWrData,
  input  logic [3:0]             ctrlWrStrbs,
  output logic [31:0]            ctrlRdData,
  output logic                   ctrlRdValid,
  input  logic [NUM_INT_BDS-1:0] opDone,
  output logic [NUM_INT_BDS-1:0] startDMAOp,
  output logic [NUM_INT_BDS-1:0] busy,
  output logic                   irq
);

  localparam int N = NUM_INT_BDS;

  localparam logic [7:0] VER_MAJOR = 8'(MAJOR_VER_NUM);
  localparam logic [7:0] VER_MINOR = 8'(MINOR_VER_NUM);
  localparam logic [7:0] VER_BUILD = 8'(BUILD_NUM);

  // Access decode
  reg_sel_t    sel;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] wr_mask;
  logic [31:0] wr_data_m;
  logic        wr_start;
  logic        wr_status;
  logic        wr_imask;
  logic        wr_cnt;

  assign sel       = decode_addr(ctrlAddr);
  assign wr_en     = ctrlSel & ctrlWr;
  assign rd_en     = ctrlSel & ~ctrlWr;
  assign wr_mask   = strb_to_mask(ctrlWrStrbs);
  assign wr_data_m = ctrlWrData & wr_mask;
  assign wr_start  = wr_en & sel.start;
  assign wr_status = wr_en & sel.status;
  assign wr_imask  = wr_en & sel.mask;
  assign wr_cnt    = wr_en & sel.cnt & (|ctrlWrStrbs);

  // State
  logic [N-1:0]  start_q, start_d;
  logic [N-1:0]  busy_q, busy_d;
  logic [N-1:0]  done_q, done_d;
  logic [N-1:0]  mask_done_q, mask_done_d;
  logic          sterr_q, sterr_d;
  logic          mask_err_q, mask_err_d;
  logic          irq_q, irq_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          rvalid_q, rvalid_d;

  logic [N-1:0]  busy_eff;
  logic [N-1:0]  start_req;
  logic [N-1:0]  start_rej;

  // Per-BD logic; a same-cycle done releases the BD before the start is judged.
  for (genvar gi = 0; gi < N; gi++) begin : g_bd
    assign start_req[gi]   = wr_start & wr_data_m[gi];
    assign busy_eff[gi]    = busy_q[gi] & ~opDone[gi];
    assign start_d[gi]     = start_req[gi] & ~busy_eff[gi];
    assign start_rej[gi]   = start_req[gi] & busy_eff[gi];
    assign busy_d[gi]      = busy_eff[gi] | start_d[gi];
    assign done_d[gi]      = (done_q[gi] & ~(wr_status & wr_data_m[gi])) | opDone[gi];
    assign mask_done_d[gi] = (wr_imask & wr_mask[gi]) ? ctrlWrData[gi] : mask_done_q[gi];
  end

  assign sterr_d    = (sterr_q & ~(wr_status & wr_data_m[STERR_BIT])) | (|start_rej);
  assign mask_err_d = (wr_imask & wr_mask[STERR_BIT]) ? ctrlWrData[STERR_BIT] : mask_err_q;
  assign irq_d      = (|(done_q & mask_done_q)) | (sterr_q & mask_err_q);

  // Completion counter
  logic [CNT_WIDTH-1:0] cnt_val;
  logic [POPCNT_W-1:0]  done_pop;

  assign done_pop = popcount({{(32-N){1'b0}}, opDone});

  dma_ctrl_sat_counter #(
    .W     (CNT_WIDTH),
    .INC_W (POPCNT_W)
  ) u_done_cnt (
    .clk_i  (clock),
    .srst_i (reset),
    .clr_i  (wr_cnt),
    .inc_i  (done_pop),
    .cnt_o  (cnt_val)
  );

  // Read mux sees only registered state, so reads return pre-update values.
  always_comb begin
    rdata_d  = '0;
    rvalid_d = rd_en;
    if (rd_en) begin
      if (sel.ver) begin
        rdata_d = {8'h00, VER_MAJOR, VER_MINOR, VER_BUILD};
      end else if (sel.busy) begin
        rdata_d[N-1:0] = busy_q;
      end else if (sel.status) begin
        rdata_d[N-1:0]       = done_q;
        rdata_d[STERR_BIT]   = sterr_q;
      end else if (sel.mask) begin
        rdata_d[N-1:0]       = mask_done_q;
        rdata_d[STERR_BIT]   = mask_err_q;
      end else if (sel.cnt) begin
        rdata_d[CNT_WIDTH-1:0] = cnt_val;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      start_q     <= '0;
      busy_q      <= '0;
      done_q      <= '0;
      mask_done_q <= '0;
      sterr_q     <= 1'b0;
      mask_err_q  <= 1'b0;
      irq_q       <= 1'b0;
      rdata_q     <= '0;
      rvalid_q    <= 1'b0;
    end else begin
      start_q     <= start_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      mask_done_q <= mask_done_d;
      sterr_q     <= sterr_d;
      mask_err_q  <= mask_err_d;
      irq_q       <= irq_d;
      rdata_q     <= rdata_d;
      rvalid_q    <= rvalid_d;
    end
  end

  assign startDMAOp  = start_q;
  assign busy        = busy_q;
  assign irq         = irq_q;
  assign ctrlRdData  = rdata_q;
  assign ctrlRdValid = rvalid_q;

  // Write-data bits beyond the implemented fields are intentionally ignored.
  logic unused_wr_bits;
  assign unused_wr_bits = ^{wr_mask, wr_data_m, ctrlWrData};

endmodule

// File: tb/tb_dma_ctrl_regs_v2.sv
// Directed bench for dma_ctrl_regs_v2 (N=4, CNT_WIDTH=4, version 2.1.5).
module tb_dma_ctrl_regs_v2;

  logic        clock;
  logic        reset;
  logic        ctrlSel;
  logic        ctrlWr;
  logic [10:0] ctrlAddr;
  logic [31:0] ctrlWrData;
  logic [3:0]  ctrlWrStrbs;
  logic [31:0] ctrlRdData;
  logic        ctrlRdValid;
  logic [3:0]  opDone;
  logic [3:0]  startDMAOp;
  logic [3:0]  busy;
  logic        irq;

  int errors = 0;
  int checks = 0;

  dma_ctrl_regs_v2 #(
    .MAJOR_VER_NUM (2),
    .MINOR_VER_NUM (1),
    .BUILD_NUM     (5),
    .NUM_INT_BDS   (4),
    .CNT_WIDTH     (4)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .ctrlSel     (ctrlSel),
    .ctrlWr      (ctrlWr),
    .ctrlAddr    (ctrlAddr),
    .ctrlWrData  (ctrlWrData),
    .ctrlWrStrbs (ctrlWrStrbs),
    .ctrlRdData  (ctrlRdData),
    .ctrlRdValid (ctrlRdValid),
    .opDone      (opDone),
    .startDMAOp  (startDMAOp),
    .busy        (busy),
    .irq         (irq)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic do_write(input logic [10:0] a, input logic [31:0] d, input logic [3:0] s);
    ctrlSel = 1'b1; ctrlWr = 1'b1; ctrlAddr = a; ctrlWrData = d; ctrlWrStrbs = s;
    cyc();
    ctrlSel = 1'b0; ctrlWr = 1'b0; ctrlWrData = '0; ctrlWrStrbs = '0;
    $display("wr  addr=%03h data=%08h strb=%h", a, d, s);
  endtask

  task automatic do_read(input logic [10:0] a, output logic [31:0] d, output logic v);
    ctrlSel = 1'b1; ctrlWr = 1'b0; ctrlAddr = a;
    cyc();
    d = ctrlRdData; v = ctrlRdValid;
    ctrlSel = 1'b0;
    $display("rd  addr=%03h data=%08h valid=%b", a, d, v);
  endtask

  task automatic test_reset();
    logic [31:0] d; logic v;
    reset = 1'b1;
    cyc(); cyc();
    reset = 1'b0;
    checks++;
    if (startDMAOp !== 4'h0 || busy !== 4'h0 || irq !== 1'b0 || ctrlRdValid !== 1'b0 || ctrlRdData !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: start=%b busy=%b irq=%b valid=%b data=%h, expected all 0", startDMAOp, busy, irq, ctrlRdValid, ctrlRdData);
    end
    do_read(11'h00C, d, v);
    checks++;
    if (d !== 32'h0 || v !== 1'b1) begin errors++; $display("FAIL reset_status: got %h/%b, expected 00000000/1", d, v); end
    do_read(11'h010, d, v);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL reset_mask: got %h, expected 00000000", d); end
  endtask

  task automatic test_version();
    logic [31:0] d; logic v;
    do_read(11'h000, d, v);
    checks++;
    if (d !== 32'h00020105 || v !== 1'b1) begin errors++; $display("FAIL ver_read: got %h/%b, expected 00020105/1", d, v); end
    cyc();
    checks++;
    if (ctrlRdValid !== 1'b0 || ctrlRdData !== 32'h0) begin
      errors++; $display("FAIL ver_idle: valid=%b data=%h, expected 0/00000000", ctrlRdValid, ctrlRdData);
    end
    do_read(11'h018, d, v);
    checks++;
    if (d !== 32'h0 || v !== 1'b1) begin errors++; $display("FAIL unmapped_read: got %h/%b, expected 00000000/1", d, v); end
  endtask

  task automatic test_start();
    logic [31:0] d; logic v;
    do_write(11'h004, 32'h5, 4'h1);
    checks++;
    if (startDMAOp !== 4'b0101 || busy !== 4'b0101 || ctrlRdValid !== 1'b0) begin
      errors++; $display("FAIL start_pulse: start=%b busy=%b valid=%b, expected 0101/0101/0", startDMAOp, busy, ctrlRdValid);
    end
    cyc();
    checks++;
    if (startDMAOp !== 4'b0000) begin errors++; $display("FAIL start_one_cycle: start=%b, expected 0000", startDMAOp); end
    do_read(11'h008, d, v);
    checks++;
    if (d !== 32'h5) begin errors++; $display("FAIL busy_read: got %h, expected 00000005", d); end
    do_read(11'h004, d, v);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL start_reads_zero: got %h, expected 00000000", d); end
    do_write(11'h004, 32'hA, 4'h0);
    checks++;
    if (startDMAOp !== 4'b0000 || busy !== 4'b0101) begin
      errors++; $display("FAIL start_nostrb: start=%b busy=%b, expected 0000/0101", startDMAOp, busy);
    end
  endtask

  task automatic test_done_irq();
    logic [31:0] d; logic v;
    do_write(11'h010, 32'h1, 4'hF);
    opDone = 4'b0001;
    cyc();
    opDone = 4'b0000;
    checks++;
    if (busy !== 4'b0100 || irq !== 1'b0) begin
      errors++; $display("FAIL done_busy_clear: busy=%b irq=%b, expected 0100/0", busy, irq);
    end
    cyc();
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL done_irq: irq=%b, expected 1", irq); end
    do_read(11'h00C, d, v);
    checks++;
    if (d !== 32'h1) begin errors++; $display("FAIL done_status: got %h, expected 00000001", d); end
    do_write(11'h00C, 32'h1, 4'h1);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL w1c_irq_lag: irq=%b, expected 1", irq); end
    cyc();
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL w1c_irq_clear: irq=%b, expected 0", irq); end
  endtask

  task automatic test_start_error();
    logic [31:0] d; logic v;
    do_write(11'h004, 32'h2, 4'h1);
    checks++;
    if (startDMAOp !== 4'b0010 || busy !== 4'b0110) begin
      errors++; $display("FAIL start_bd1: start=%b busy=%b, expected 0010/0110", startDMAOp, busy);
    end
    do_write(11'h004, 32'h3, 4'h1);
    checks++;
    if (startDMAOp !== 4'b0001 || busy !== 4'b0111) begin
      errors++; $display("FAIL start_mixed: start=%b busy=%b, expected 0001/0111", startDMAOp, busy);
    end
    do_read(11'h00C, d, v);
    checks++;
    if (d !== 32'h80000000) begin errors++; $display("FAIL sterr_status: got %h, expected 80000000", d); end
    cyc();
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL sterr_masked: irq=%b, expected 0", irq); end
    do_write(11'h010, 32'h80000001, 4'hF);
    cyc();
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL sterr_irq: irq=%b, expected 1", irq); end
    do_read(11'h010, d, v);
    checks++;
    if (d !== 32'h80000001) begin errors++; $display("FAIL mask_read: got %h, expected 80000001", d); end
    do_write(11'h00C, 32'h80000000, 4'h8);
    cyc();
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL sterr_clear_irq: irq=%b, expected 0", irq); end
  endtask

  task automatic test_collision();
    logic [31:0] d; logic v;
    ctrlSel = 1'b1; ctrlWr = 1'b1; ctrlAddr = 11'h004; ctrlWrData = 32'h4; ctrlWrStrbs = 4'h1;
    opDone = 4'b0100;
    cyc();
    ctrlSel = 1'b0; ctrlWr = 1'b0; ctrlWrStrbs = '0; opDone = 4'b0000;
    $display("wr  addr=004 data=00000004 strb=1 with opDone=0100");
    checks++;
    if (startDMAOp !== 4'b0100 || busy !== 4'b0111) begin
      errors++; $display("FAIL collide_start: start=%b busy=%b, expected 0100/0111", startDMAOp, busy);
    end
    do_read(11'h00C, d, v);
    checks++;
    if (d !== 32'h4) begin errors++; $display("FAIL collide_done: got %h, expected 00000004", d); end
    ctrlSel = 1'b1; ctrlWr = 1'b1; ctrlAddr = 11'h00C; ctrlWrData = 32'h4; ctrlWrStrbs = 4'h1;
    opDone = 4'b0100;
    cyc();
    ctrlSel = 1'b0; ctrlWr = 1'b0; ctrlWrStrbs = '0; opDone = 4'b0000;
    $display("wr  addr=00c data=00000004 strb=1 with opDone=0100");
    do_read(11'h00C, d, v);
    checks++;
    if (d !== 32'h4 || busy !== 4'b0011) begin
      errors++; $display("FAIL set_wins: status=%h busy=%b, expected 00000004/0011", d, busy);
    end
    do_write(11'h00C, 32'h4, 4'h1);
    do_read(11'h00C, d, v);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL w1c_done2: got %h, expected 00000000", d); end
  endtask

  task automatic test_counter();
    logic [31:0] d; logic v;
    do_read(11'h014, d, v);
    checks++;
    if (d !== 32'h3) begin errors++; $display("FAIL cnt_accum: got %h, expected 00000003", d); end
    do_write(11'h014, 32'h0, 4'h1);
    opDone = 4'b1111;
    for (int i = 0; i < 5; i++) cyc();
    opDone = 4'b0000;
    do_read(11'h014, d, v);
    checks++;
    if (d !== 32'hF) begin errors++; $display("FAIL cnt_saturate: got %h, expected 0000000f", d); end
    ctrlSel = 1'b1; ctrlWr = 1'b1; ctrlAddr = 11'h014; ctrlWrData = 32'h0; ctrlWrStrbs = 4'h2;
    opDone = 4'b0011;
    cyc();
    ctrlSel = 1'b0; ctrlWr = 1'b0; ctrlWrStrbs = '0; opDone = 4'b0000;
    $display("wr  addr=014 data=00000000 strb=2 with opDone=0011");
    do_read(11'h014, d, v);
    checks++;
    if (d !== 32'h2) begin errors++; $display("FAIL cnt_clear_load: got %h, expected 00000002", d); end
    do_write(11'h014, 32'hFFFFFFFF, 4'h0);
    do_read(11'h014, d, v);
    checks++;
    if (d !== 32'h2) begin errors++; $display("FAIL cnt_nostrb: got %h, expected 00000002", d); end
  endtask

  task automatic test_back_to_back();
    logic [10:0] addrs [3];
    logic [31:0] exp_d [3];
    addrs = '{11'h000, 11'h008, 11'h014};
    exp_d = '{32'h00020105, 32'h0, 32'h2};
    ctrlSel = 1'b1; ctrlWr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ctrlAddr = addrs[i];
      cyc();
      $display("rd  addr=%03h data=%08h valid=%b (back-to-back)", addrs[i], ctrlRdData, ctrlRdValid);
      checks++;
      if (ctrlRdData !== exp_d[i] || ctrlRdValid !== 1'b1) begin
        errors++; $display("FAIL b2b_read%0d: got %h/%b, expected %h/1", i, ctrlRdData, ctrlRdValid, exp_d[i]);
      end
    end
    ctrlSel = 1'b0;
    cyc();
    checks++;
    if (ctrlRdValid !== 1'b0 || ctrlRdData !== 32'h0) begin
      errors++; $display("FAIL b2b_end: valid=%b data=%h, expected 0/00000000", ctrlRdValid, ctrlRdData);
    end
  endtask

  task automatic test_reset_midread();
    logic [31:0] d; logic v;
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL pre_reset_irq: irq=%b, expected 1", irq); end
    ctrlSel = 1'b1; ctrlWr = 1'b0; ctrlAddr = 11'h000;
    reset = 1'b1;
    cyc();
    ctrlSel = 1'b0; reset = 1'b0;
    $display("rd  addr=000 issued during reset");
    checks++;
    if (ctrlRdValid !== 1'b0 || ctrlRdData !== 32'h0 || irq !== 1'b0 || busy !== 4'h0) begin
      errors++; $display("FAIL reset_midread: valid=%b data=%h irq=%b busy=%b, expected 0/00000000/0/0000", ctrlRdValid, ctrlRdData, irq, busy);
    end
    do_read(11'h00C, d, v);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL reset_status2: got %h, expected 00000000", d); end
    do_read(11'h010, d, v);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL reset_mask2: got %h, expected 00000000", d); end
    do_read(11'h014, d, v);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL reset_cnt: got %h, expected 00000000", d); end
  endtask

  initial begin
    reset = 1'b1; ctrlSel = 1'b0; ctrlWr = 1'b0; ctrlAddr = '0;
    ctrlWrData = '0; ctrlWrStrbs = '0; opDone = '0;
    test_reset();
    test_version();
    test_start();
    test_done_irq();
    test_start_error();
    test_collision();
    test_counter();
    test_back_to_back();
    test_reset_midread();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
